// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the AXI-Stream round-robin arbiter.
package axis_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Index width for N requesters; never below one bit so N = 1 still has a port.
  function automatic int unsigned idx_w(int unsigned n);
    return (n <= 32'd1) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/axis_rr_arbiter_if.sv
// Bundle of requester-side and downstream AXI-Stream signals for the arbiter.
interface axis_rr_arbiter_if #(
  parameter int unsigned N     = 4,
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned IDX_W = axis_arb_pkg::idx_w(N);
  localparam int unsigned KW    = WIDTH / 8;

  logic [N-1:0]       s_valid;
  logic [N-1:0]       s_ready;
  logic [N-1:0]       s_last;
  logic [N*WIDTH-1:0] s_data;
  logic [N*KW-1:0]    s_keep;
  logic               m_ready;
  logic               m_valid;
  logic               m_last;
  logic [WIDTH-1:0]   m_data;
  logic [KW-1:0]      m_keep;
  logic [IDX_W-1:0]   m_grant;

  modport master (
    output s_valid, s_last, s_data, s_keep, m_ready,
    input  s_ready, m_valid, m_last, m_data, m_keep, m_grant
  );

  modport slave (
    input  s_valid, s_last, s_data, s_keep, m_ready,
    output s_ready, m_valid, m_last, m_data, m_keep, m_grant
  );

endinterface

// File: rtl/axis_rr_pick.sv
// Combinational round-robin picker: first requester above 'last', wrapping modulo N.
module axis_rr_pick import axis_arb_pkg::*; #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [idx_w(N)-1:0]  last,
  output logic [idx_w(N)-1:0]  pick,
  output logic                 any
);
  localparam int unsigned IDX_W = idx_w(N);

  logic [IDX_W-1:0] idx;

  always_comb begin
    pick = '0;
    any  = 1'b0;
    idx  = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = IDX_W'((32'(last) + k) % N);
      if (!any && req[idx]) begin
        any  = 1'b1;
        pick = idx;
      end
    end
  end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-granular round-robin AXI-Stream arbiter: N requesters merged onto one stream.
module axis_rr_arbiter import axis_arb_pkg::*; #(
  parameter int unsigned N     = 4,
  parameter int unsigned WIDTH = 8
) (
  input logic              aclk,
  input logic              aresetn,
  axis_rr_arbiter_if.slave bus
);
  localparam int unsigned IDX_W = idx_w(N);
  localparam int unsigned KW    = WIDTH / 8;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] last_grant_q, last_grant_d;
  logic [IDX_W-1:0] pick;
  logic             any;
  logic             busy;
  logic             xfer_last;
  logic [31:0]      sel;

  axis_rr_pick #(
    .N(N)
  ) u_pick (
    .req  (bus.s_valid),
    .last (last_grant_q),
    .pick (pick),
    .any  (any)
  );

  assign busy      = (state_q == BUSY);
  assign sel       = 32'(grant_q);
  assign xfer_last = busy && bus.s_valid[grant_q] && bus.s_last[grant_q] && bus.m_ready;
  assign bus.m_grant = grant_q;

  // Output mux is purely combinational so beats pass with zero latency once granted.
  always_comb begin
    bus.m_valid = 1'b0;
    bus.m_last  = 1'b0;
    bus.m_data  = '0;
    bus.m_keep  = '0;
    bus.s_ready = '0;
    if (busy) begin
      bus.m_valid          = bus.s_valid[grant_q];
      bus.m_last           = bus.s_last[grant_q];
      bus.m_data           = bus.s_data[sel*WIDTH +: WIDTH];
      bus.m_keep           = bus.s_keep[sel*KW +: KW];
      bus.s_ready[grant_q] = bus.m_ready;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (any) begin
          grant_d = pick;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (xfer_last) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // last_grant resets to N-1 so the first search begins at requester 0.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(N - 1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed bench for axis_rr_arbiter: per-requester source queues plus an ordered scoreboard.
module tb_axis_rr_arbiter;
  localparam int unsigned N     = 4;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned KW    = WIDTH / 8;
  localparam int unsigned IDX_W = axis_arb_pkg::idx_w(N);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [KW-1:0]    keep;
    logic             last;
  } src_t;

  typedef struct packed {
    logic [IDX_W-1:0] grant;
    logic [WIDTH-1:0] data;
    logic [KW-1:0]    keep;
    logic             last;
  } exp_t;

  logic aclk = 1'b0;
  logic aresetn;

  axis_rr_arbiter_if #(.N(N), .WIDTH(WIDTH)) bus ();

  axis_rr_arbiter #(
    .N     (N),
    .WIDTH (WIDTH)
  ) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  always #5 aclk = ~aclk;

  src_t             srcq[N][$];
  exp_t             expq[$];
  logic [N-1:0]     vmask;
  int               checks = 0;
  int               errors = 0;
  int               xfer_cnt = 0;
  logic             obs_mvalid;
  logic [N-1:0]     obs_sready;
  logic [IDX_W-1:0] obs_grant;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    logic [N-1:0]       sv, sl;
    logic [N*WIDTH-1:0] sd;
    logic [N*KW-1:0]    sk;
    sv = '0; sl = '0; sd = '0; sk = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (vmask[i] && srcq[i].size() > 0) begin
        sv[i]                = 1'b1;
        sl[i]                = srcq[i][0].last;
        sd[i*WIDTH +: WIDTH] = srcq[i][0].data;
        sk[i*KW +: KW]       = srcq[i][0].keep;
      end
    end
    bus.s_valid = sv;
    bus.s_last  = sl;
    bus.s_data  = sd;
    bus.s_keep  = sk;
  endtask

  // Queue a packet on requester 'req' and append its beats to the expected output order.
  task automatic add_pkt(input int req, input int len, input logic [7:0] base,
                         input logic [7:0] step);
    src_t s;
    exp_t e;
    for (int k = 0; k < len; k++) begin
      s.data = base + 8'(k) * step;
      s.keep = (k % 2 == 1) ? '0 : '1;
      s.last = (k == len - 1);
      srcq[req].push_back(s);
      e.grant = IDX_W'(req);
      e.data  = s.data;
      e.keep  = s.keep;
      e.last  = s.last;
      expq.push_back(e);
    end
  endtask

  // One clock: observe at the falling edge, then drive fresh inputs just after the rising edge.
  task automatic cycle();
    exp_t e;
    @(negedge aclk);
    obs_mvalid = bus.m_valid;
    obs_sready = bus.s_ready;
    obs_grant  = bus.m_grant;
    if (bus.m_valid && bus.m_ready) begin
      xfer_cnt++;
      if (expq.size() == 0) begin
        chk("spurious_beat", 32'(bus.m_valid), 32'd0);
      end else begin
        e = expq.pop_front();
        chk("beat_grant", 32'(bus.m_grant), 32'(e.grant));
        chk("beat_data", 32'(bus.m_data), 32'(e.data));
        chk("beat_keep", 32'(bus.m_keep), 32'(e.keep));
        chk("beat_last", 32'(bus.m_last), 32'(e.last));
      end
    end
    for (int i = 0; i < int'(N); i++) begin
      if (bus.s_valid[i] && bus.s_ready[i]) void'(srcq[i].pop_front());
    end
    @(posedge aclk);
    #1;
    drive();
  endtask

  task automatic run_until_empty(input int budget);
    int n = 0;
    while (expq.size() > 0 && n < budget) begin
      cycle();
      n++;
    end
    chk("drain", 32'(expq.size()), 32'd0);
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
  endtask

  initial begin : stim
    logic [4:0] p1;
    logic [9:0] p2;
    p1 = 5'b01110;
    p2 = 10'b1010101010;
    vmask       = '1;
    bus.m_ready = 1'b1;
    aresetn     = 1'b1;
    bus.s_valid = '1;
    bus.s_last  = '1;
    bus.s_data  = '1;
    bus.s_keep  = '1;
    #1 aresetn = 1'b0;
    #2;
    chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
    chk("rst_m_last", 32'(bus.m_last), 32'd0);
    chk("rst_m_data", 32'(bus.m_data), 32'd0);
    chk("rst_m_keep", 32'(bus.m_keep), 32'd0);
    chk("rst_m_grant", 32'(bus.m_grant), 32'd0);
    chk("rst_s_ready", 32'(bus.s_ready), 32'd0);
    repeat (2) @(posedge aclk);
    #1;

    // Single requester, 3-beat packet: bubble, three beats, back to idle.
    add_pkt(0, 3, 8'h11, 8'h11);
    drive();
    aresetn = 1'b1;
    for (int c = 0; c < 5; c++) begin
      cycle();
      chk("t1_m_valid", 32'(obs_mvalid), 32'(p1[c]));
    end
    chk("t1_grant", 32'(obs_grant), 32'd0);
    chk("t1_done", 32'(expq.size()), 32'd0);

    // All requesters busy with 1-beat packets: order 0,1,2,3,0, a beat every other cycle.
    do_reset();
    add_pkt(0, 1, 8'hA0, 8'h01);
    add_pkt(1, 1, 8'hA1, 8'h01);
    add_pkt(2, 1, 8'hA2, 8'h01);
    add_pkt(3, 1, 8'hA3, 8'h01);
    add_pkt(0, 1, 8'hA4, 8'h01);
    drive();
    for (int c = 0; c < 10; c++) begin
      cycle();
      chk("t2_m_valid", 32'(obs_mvalid), 32'(p2[c]));
    end
    cycle();
    chk("t2_idle", 32'(obs_mvalid), 32'd0);
    chk("t2_done", 32'(expq.size()), 32'd0);

    // Requester 2 arrives mid-packet of requester 1, which also drops valid for a cycle.
    do_reset();
    add_pkt(1, 4, 8'h40, 8'h01);
    drive();
    repeat (3) cycle();
    add_pkt(2, 1, 8'h50, 8'h01);
    vmask[1] = 1'b0;
    drive();
    cycle();
    chk("t3_gap_valid", 32'(obs_mvalid), 32'd0);
    chk("t3_gap_grant", 32'(obs_grant), 32'd1);
    chk("t3_gap_ready2", 32'(obs_sready[2]), 32'd0);
    vmask[1] = 1'b1;
    drive();
    for (int c = 0; c < 2; c++) begin
      cycle();
      chk("t3_ready2", 32'(obs_sready[2]), 32'd0);
      chk("t3_grant", 32'(obs_grant), 32'd1);
    end
    run_until_empty(10);

    // Downstream backpressure toggling 1,0,1,0 over a 4-beat packet on requester 3.
    add_pkt(3, 4, 8'h60, 8'h10);
    drive();
    cycle();
    xfer_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      bus.m_ready = (k % 2 == 0);
      cycle();
      chk("t4_s_ready", 32'(obs_sready), (k % 2 == 0) ? 32'h8 : 32'h0);
    end
    chk("t4_xfers", 32'(xfer_cnt), 32'd4);
    chk("t4_done", 32'(expq.size()), 32'd0);
    bus.m_ready = 1'b1;

    // Reset during beat 2 of 4 abandons the packet; a new requester starts clean.
    add_pkt(0, 4, 8'h80, 8'h01);
    drive();
    repeat (2) cycle();
    aresetn = 1'b0;
    #1;
    chk("t5_m_valid", 32'(bus.m_valid), 32'd0);
    chk("t5_m_data", 32'(bus.m_data), 32'd0);
    chk("t5_m_keep", 32'(bus.m_keep), 32'd0);
    chk("t5_m_last", 32'(bus.m_last), 32'd0);
    chk("t5_s_ready", 32'(bus.s_ready), 32'd0);
    chk("t5_m_grant", 32'(bus.m_grant), 32'd0);
    chk("t5_pending", 32'(expq.size()), 32'd3);
    srcq[0].delete();
    expq.delete();
    add_pkt(2, 2, 8'h90, 8'h01);
    drive();
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    run_until_empty(10);
    cycle();
    chk("t5_idle", 32'(obs_mvalid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
